// File: rtl/instr_fetch_reg.sv
// Instruction fetch with timeout abort, instruction register decode and ALU status flags.
// Only busy_o is combinational; every other output comes straight from a register.
module instr_fetch_reg #(
    parameter int DATA_WIDTH   = 16,
    parameter int OPCODE_WIDTH = 7,
    parameter int TIMEOUT      = 15
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    fetch_i,
    input  logic [DATA_WIDTH-1:0]   mem_data_i,
    input  logic                    mem_ack_i,
    input  logic                    alu_carry_i,
    input  logic                    alu_zero_i,
    input  logic                    flags_load_i,
    input  logic                    flags_clear_i,
    output logic                    mem_req_o,
    output logic [OPCODE_WIDTH-1:0] opcode_o,
    output logic [2:0]              opnd_a_o,
    output logic [2:0]              opnd_b_o,
    output logic [2:0]              opnd_c_o,
    output logic                    carry_o,
    output logic                    zero_o,
    output logic                    busy_o,
    output logic                    ir_valid_o,
    output logic                    bus_error_o
);

    typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t                  state_q, state_d;
    logic [7:0]              cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   ir_q, ir_d;
    logic                    mem_req_q, mem_req_d;
    logic                    ir_valid_q, ir_valid_d;
    logic                    bus_error_q, bus_error_d;
    logic                    carry_q, carry_d;
    logic                    zero_q, zero_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            ir_q        <= '0;
            mem_req_q   <= 1'b0;
            ir_valid_q  <= 1'b0;
            bus_error_q <= 1'b0;
            carry_q     <= 1'b0;
            zero_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ir_q        <= ir_d;
            mem_req_q   <= mem_req_d;
            ir_valid_q  <= ir_valid_d;
            bus_error_q <= bus_error_d;
            carry_q     <= carry_d;
            zero_q      <= zero_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ir_d        = ir_q;
        mem_req_d   = mem_req_q;
        ir_valid_d  = ir_valid_q;
        bus_error_d = bus_error_q;
        unique case (state_q)
            IDLE: begin
                if (fetch_i) begin
                    state_d    = WAIT;
                    mem_req_d  = 1'b1;
                    ir_valid_d = 1'b0;
                    cnt_d      = '0;
                end
            end
            WAIT: begin
                // An ack on the timeout edge still completes the fetch.
                if (mem_ack_i) begin
                    state_d    = IDLE;
                    ir_d       = mem_data_i;
                    ir_valid_d = 1'b1;
                    mem_req_d  = 1'b0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d     = IDLE;
                    mem_req_d   = 1'b0;
                    bus_error_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        carry_d = carry_q;
        zero_d  = zero_q;
        if (flags_clear_i) begin
            carry_d = 1'b0;
            zero_d  = 1'b0;
        end else if (flags_load_i) begin
            carry_d = alu_carry_i;
            zero_d  = alu_zero_i;
        end
    end

    assign busy_o      = (state_q == WAIT);
    assign mem_req_o   = mem_req_q;
    assign opcode_o    = ir_q[DATA_WIDTH-1 -: OPCODE_WIDTH];
    assign opnd_a_o    = ir_q[8:6];
    assign opnd_b_o    = ir_q[5:3];
    assign opnd_c_o    = ir_q[2:0];
    assign ir_valid_o  = ir_valid_q;
    assign bus_error_o = bus_error_q;
    assign carry_o     = carry_q;
    assign zero_o      = zero_q;

endmodule

// File: tb/tb_instr_fetch_reg.sv
// Bench for instr_fetch_reg: directed checks plus a scoreboard of fetched words,
// compared whenever ir_valid rises.
module tb_instr_fetch_reg;

    logic        clk_i = 1'b0;
    logic        rst_i, fetch_i, mem_ack_i;
    logic [15:0] mem_data_i;
    logic        alu_carry_i, alu_zero_i, flags_load_i, flags_clear_i;
    logic        mem_req_o, carry_o, zero_o, busy_o, ir_valid_o, bus_error_o;
    logic [6:0]  opcode_o;
    logic [2:0]  opnd_a_o, opnd_b_o, opnd_c_o;

    int n_tests = 0;
    int n_fail  = 0;
    int n_done  = 0;
    logic [15:0] sb_q[$];
    logic iv_prev = 1'b0;

    instr_fetch_reg #(.DATA_WIDTH(16), .OPCODE_WIDTH(7), .TIMEOUT(15)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .fetch_i(fetch_i), .mem_data_i(mem_data_i),
        .mem_ack_i(mem_ack_i), .alu_carry_i(alu_carry_i), .alu_zero_i(alu_zero_i),
        .flags_load_i(flags_load_i), .flags_clear_i(flags_clear_i),
        .mem_req_o(mem_req_o), .opcode_o(opcode_o), .opnd_a_o(opnd_a_o),
        .opnd_b_o(opnd_b_o), .opnd_c_o(opnd_c_o), .carry_o(carry_o), .zero_o(zero_o),
        .busy_o(busy_o), .ir_valid_o(ir_valid_o), .bus_error_o(bus_error_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Scoreboard: each completed fetch must present the next queued word.
    always @(negedge clk_i) begin
        if (ir_valid_o && !iv_prev) begin
            n_done++;
            if (sb_q.size() == 0) chk("sb_unexpected", 32'(ir_valid_o), 32'd0);
            else chk("sb_ir", 32'({opcode_o, opnd_a_o, opnd_b_o, opnd_c_o}), 32'(sb_q.pop_front()));
        end
        iv_prev = ir_valid_o;
    end

    initial begin
        int n;
        int done0;
        rst_i = 1; fetch_i = 0; mem_ack_i = 0; mem_data_i = 16'h0;
        alu_carry_i = 0; alu_zero_i = 0; flags_load_i = 0; flags_clear_i = 0;
        tick(); tick();
        rst_i = 0;
        chk("rst_mem_req", 32'(mem_req_o), 0);
        chk("rst_busy", 32'(busy_o), 0);
        chk("rst_ir_valid", 32'(ir_valid_o), 0);
        chk("rst_bus_error", 32'(bus_error_o), 0);
        chk("rst_flags", 32'({carry_o, zero_o}), 0);
        chk("rst_ir", 32'({opcode_o, opnd_a_o, opnd_b_o, opnd_c_o}), 0);

        // Basic fetch, ack sampled on the second WAIT edge.
        fetch_i = 1; tick(); fetch_i = 0;
        chk("f1_req", 32'(mem_req_o), 1);
        chk("f1_busy", 32'(busy_o), 1);
        tick();
        chk("f1_req2", 32'(mem_req_o), 1);
        mem_ack_i = 1; mem_data_i = 16'hA5C3; sb_q.push_back(16'hA5C3);
        tick(); mem_ack_i = 0;
        chk("f1_req_drop", 32'(mem_req_o), 0);
        chk("f1_busy_drop", 32'(busy_o), 0);
        chk("f1_ir_valid", 32'(ir_valid_o), 1);
        chk("f1_opcode", 32'(opcode_o), 32'h52);
        chk("f1_a", 32'(opnd_a_o), 7);
        chk("f1_b", 32'(opnd_b_o), 0);
        chk("f1_c", 32'(opnd_c_o), 3);

        // Ack while idle is ignored.
        mem_ack_i = 1; mem_data_i = 16'h1111; tick(); mem_ack_i = 0;
        chk("idle_ack_opcode", 32'(opcode_o), 32'h52);
        chk("idle_ack_busy", 32'(busy_o), 0);

        // Timeout; fetch pulsed mid-wait must not restart the counter.
        fetch_i = 1; tick(); fetch_i = 0;
        n = 0;
        while (mem_req_o && n < 40) begin
            fetch_i = (n >= 3 && n < 10);
            n++;
            tick();
        end
        fetch_i = 0;
        chk("to_req_cycles", 32'(n), 15);
        chk("to_bus_error", 32'(bus_error_o), 1);
        chk("to_ir_valid", 32'(ir_valid_o), 0);
        chk("to_opcode", 32'(opcode_o), 32'h52);
        chk("to_busy", 32'(busy_o), 0);

        // Sticky bus_error, normal fetch afterwards.
        fetch_i = 1; tick(); fetch_i = 0;
        mem_ack_i = 1; mem_data_i = 16'h1234; sb_q.push_back(16'h1234);
        tick(); mem_ack_i = 0;
        chk("sticky_bus_error", 32'(bus_error_o), 1);
        chk("sticky_ir_valid", 32'(ir_valid_o), 1);

        rst_i = 1; tick(); rst_i = 0;
        chk("rst2_bus_error", 32'(bus_error_o), 0);

        // Ack exactly on the timeout edge wins.
        fetch_i = 1; tick(); fetch_i = 0;
        repeat (14) tick();
        chk("edge_req_before", 32'(mem_req_o), 1);
        mem_ack_i = 1; mem_data_i = 16'h0001; sb_q.push_back(16'h0001);
        tick(); mem_ack_i = 0;
        chk("edge_bus_error", 32'(bus_error_o), 0);
        chk("edge_ir_valid", 32'(ir_valid_o), 1);
        chk("edge_ir", 32'({opcode_o, opnd_a_o, opnd_b_o, opnd_c_o}), 32'h0001);
        chk("edge_req", 32'(mem_req_o), 0);

        // Flags: load, clear-wins, reload, hold, partial load.
        alu_carry_i = 1; alu_zero_i = 1; flags_load_i = 1; tick();
        chk("fl_load", 32'({carry_o, zero_o}), 32'b11);
        flags_clear_i = 1; tick(); flags_clear_i = 0;
        chk("fl_clear_wins", 32'({carry_o, zero_o}), 32'b00);
        tick();
        chk("fl_reload", 32'({carry_o, zero_o}), 32'b11);
        flags_load_i = 0; alu_carry_i = 0; alu_zero_i = 0; tick();
        chk("fl_hold", 32'({carry_o, zero_o}), 32'b11);
        alu_carry_i = 1; flags_load_i = 1; fetch_i = 1; tick(); flags_load_i = 0; fetch_i = 0;
        chk("fl_load_in_wait", 32'({carry_o, zero_o}), 32'b10);

        // Reset mid-WAIT with a simultaneous ack.
        chk("rstw_busy_before", 32'(busy_o), 1);
        rst_i = 1; mem_ack_i = 1; mem_data_i = 16'hFFFF; tick();
        rst_i = 0; mem_ack_i = 0;
        chk("rstw_ir", 32'({opcode_o, opnd_a_o, opnd_b_o, opnd_c_o}), 0);
        chk("rstw_ir_valid", 32'(ir_valid_o), 0);
        chk("rstw_req", 32'(mem_req_o), 0);
        chk("rstw_busy", 32'(busy_o), 0);
        chk("rstw_flags", 32'({carry_o, zero_o}), 0);

        // Back-to-back: fetch and ack both held, one completion every two edges.
        #4;
        done0 = n_done;
        fetch_i = 1; mem_ack_i = 1;
        for (int i = 0; i < 8; i++) begin
            mem_data_i = 16'h1000 + 16'(i * 16'h0111);
            if (i % 2 == 1) sb_q.push_back(mem_data_i);
            tick();
        end
        fetch_i = 0; mem_ack_i = 0;
        tick(); #5;
        chk("b2b_completions", 32'(n_done - done0), 4);
        chk("sb_drained", 32'(sb_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
